// File: rtl/cdm8_mon_pkg.sv
// Shared types and constants for the CDM8 approximate-multiplier error monitor.
package cdm8_mon_pkg;

  localparam int W_DEF = 8;
  localparam int P_W   = 2 * W_DEF;
  localparam int ED_W  = 2 * W_DEF;

  // All-ones source; slice it to a width to get that width's saturation limit.
  localparam logic [63:0] SAT_ONES = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cdm8_ed_stage.sv
// Stage 1 of the monitor pipeline: registers the sample and its exact product,
// then presents the error distance |exact - r| combinationally from those flops.
module cdm8_ed_stage
  import cdm8_mon_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_vld,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic [2*W-1:0] in_r,
  output logic           out_vld,
  output logic [W-1:0]   out_a,
  output logic [W-1:0]   out_b,
  output logic [2*W-1:0] out_ed
);

  logic           vld_q, vld_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] r_q, r_d;
  logic [2*W-1:0] exact_q, exact_d;

  logic signed [2*W:0] diff;
  logic        [2*W:0] mag;

  always_comb begin
    vld_d   = in_vld;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    exact_d = exact_q;
    if (in_vld) begin
      a_d     = in_a;
      b_d     = in_b;
      r_d     = in_r;
      exact_d = {{W{1'b0}}, in_a} * {{W{1'b0}}, in_b};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      exact_q <= '0;
    end else begin
      vld_q   <= vld_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      exact_q <= exact_d;
    end
  end

  // One extra bit keeps the sign of exact - r; the magnitude always fits in 2W.
  always_comb begin
    diff = $signed({1'b0, exact_q}) - $signed({1'b0, r_q});
    mag  = diff[2*W] ? -diff : diff;
  end

  assign out_vld = vld_q;
  assign out_a   = a_q;
  assign out_b   = b_q;
  assign out_ed  = mag[2*W-1:0];

endmodule

// File: rtl/cdm8_err_monitor.sv
// Streaming error-metrics engine: accepts (A, B, R) samples for one frame and
// accumulates count, error count, saturating sum and first-occurrence max of |A*B - R|.
module cdm8_err_monitor
  import cdm8_mon_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int ACC_W = 32,
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [2*W-1:0]   in_r,
  input  logic             in_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_ed,
  output logic [2*W-1:0]   max_ed,
  output logic [W-1:0]     max_a,
  output logic [W-1:0]     max_b,
  output logic             sat
);

  localparam int EW    = 2 * W;
  localparam int SUM_W = ((ACC_W > EW) ? ACC_W : EW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = SAT_ONES[CNT_W-1:0];
  localparam logic [ACC_W-1:0] ACC_MAX = SAT_ONES[ACC_W-1:0];

  state_e state_q, state_d;

  logic accept;
  logic clear;

  logic          s1_vld;
  logic [W-1:0]  s1_a, s1_b;
  logic [EW-1:0] s1_ed;

  logic          s2_vld_q, s2_vld_d;
  logic [W-1:0]  s2_a_q, s2_a_d;
  logic [W-1:0]  s2_b_q, s2_b_d;
  logic [EW-1:0] s2_ed_q, s2_ed_d;

  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
  logic [EW-1:0]    max_ed_q, max_ed_d;
  logic [W-1:0]     max_a_q, max_a_d;
  logic [W-1:0]     max_b_q, max_b_d;
  logic             sat_q, sat_d;

  logic [SUM_W-1:0] sum_ext;
  logic [SUM_W-1:0] sum_lim;

  assign accept = in_valid & (state_q == RUN);
  assign clear  = start & ((state_q == IDLE) | (state_q == DONE));

  cdm8_ed_stage #(.W(W)) u_ed_stage (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (accept),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_r    (in_r),
    .out_vld (s1_vld),
    .out_a   (s1_a),
    .out_b   (s1_b),
    .out_ed  (s1_ed)
  );

  // DRAIN can never accept, so once stage 1 is empty the stage-2 sample (if any)
  // retires on this edge and the metrics are final together with done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (accept && in_last) state_d = DRAIN;
      DRAIN:      if (!s1_vld) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    s2_vld_d = s1_vld;
    s2_a_d   = s2_a_q;
    s2_b_d   = s2_b_q;
    s2_ed_d  = s2_ed_q;
    if (s1_vld) begin
      s2_a_d  = s1_a;
      s2_b_d  = s1_b;
      s2_ed_d = s1_ed;
    end
  end

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    sum_ed_d     = sum_ed_q;
    max_ed_d     = max_ed_q;
    max_a_d      = max_a_q;
    max_b_d      = max_b_q;
    sat_d        = sat_q;
    sum_ext      = {{(SUM_W-ACC_W){1'b0}}, sum_ed_q} + {{(SUM_W-EW){1'b0}}, s2_ed_q};
    sum_lim      = {{(SUM_W-ACC_W){1'b0}}, ACC_MAX};
    if (clear) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      sum_ed_d     = '0;
      max_ed_d     = '0;
      max_a_d      = '0;
      max_b_d      = '0;
      sat_d        = 1'b0;
    end else if (s2_vld_q) begin
      if (sample_cnt_q == CNT_MAX) sat_d = 1'b1;
      else                         sample_cnt_d = sample_cnt_q + 1'b1;
      if (s2_ed_q != '0) begin
        if (err_cnt_q == CNT_MAX) sat_d = 1'b1;
        else                      err_cnt_d = err_cnt_q + 1'b1;
      end
      if (sum_ext > sum_lim) begin
        sum_ed_d = ACC_MAX;
        sat_d    = 1'b1;
      end else begin
        sum_ed_d = sum_ext[ACC_W-1:0];
      end
      // Strictly greater: a later tie keeps the earliest location.
      if (s2_ed_q > max_ed_q) begin
        max_ed_d = s2_ed_q;
        max_a_d  = s2_a_q;
        max_b_d  = s2_b_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      s2_vld_q     <= 1'b0;
      s2_a_q       <= '0;
      s2_b_q       <= '0;
      s2_ed_q      <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_ed_q     <= '0;
      max_ed_q     <= '0;
      max_a_q      <= '0;
      max_b_q      <= '0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      s2_vld_q     <= s2_vld_d;
      s2_a_q       <= s2_a_d;
      s2_b_q       <= s2_b_d;
      s2_ed_q      <= s2_ed_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      sum_ed_q     <= sum_ed_d;
      max_ed_q     <= max_ed_d;
      max_a_q      <= max_a_d;
      max_b_q      <= max_b_d;
      sat_q        <= sat_d;
    end
  end

  assign in_ready   = (state_q == RUN);
  assign busy       = (state_q == RUN) | (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign sum_ed     = sum_ed_q;
  assign max_ed     = max_ed_q;
  assign max_a      = max_a_q;
  assign max_b      = max_b_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_cdm8_err_monitor.sv
// Scoreboard bench: a default build and an ACC_W=8 build see the same stimulus;
// frame results are predicted from the metric definitions and checked on done.
module tb_cdm8_err_monitor;

  localparam int ACC_W = 32;
  localparam int ACC_S = 8;
  localparam int CNT_W = 17;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_last;
  logic [7:0]  in_a, in_b;
  logic [15:0] in_r;

  logic in_ready, busy, done, sat;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [ACC_W-1:0] sum_ed;
  logic [15:0] max_ed;
  logic [7:0]  max_a, max_b;

  logic s_in_ready, s_busy, s_done, s_sat;
  logic [CNT_W-1:0] s_sample_cnt, s_err_cnt;
  logic [ACC_S-1:0] s_sum_ed;
  logic [15:0] s_max_ed;
  logic [7:0]  s_max_a, s_max_b;

  always #5 clk = ~clk;

  cdm8_err_monitor #(.W(8), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_r(in_r), .in_last(in_last), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .sum_ed(sum_ed), .max_ed(max_ed),
    .max_a(max_a), .max_b(max_b), .sat(sat)
  );

  cdm8_err_monitor #(.W(8), .ACC_W(ACC_S), .CNT_W(CNT_W)) dut_s (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_r(in_r), .in_last(in_last), .busy(s_busy), .done(s_done),
    .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt), .sum_ed(s_sum_ed), .max_ed(s_max_ed),
    .max_a(s_max_a), .max_b(s_max_b), .sat(s_sat)
  );

  typedef struct {
    longint cnt, err, sum, maxed, maxa, maxb, sat;
  } mres_t;

  mres_t m_main, m_sat;
  mres_t q_main[$];
  mres_t q_sat[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_step(inout mres_t m, input longint a, input longint b,
                                     input longint r, input int acc_w);
    longint ed, cmax, smax;
    ed = a * b - r;
    if (ed < 0) ed = -ed;
    cmax = (longint'(1) << CNT_W) - 1;
    smax = (longint'(1) << acc_w) - 1;
    if (m.cnt == cmax) m.sat = 1; else m.cnt++;
    if (ed != 0) begin
      if (m.err == cmax) m.sat = 1; else m.err++;
    end
    if (m.sum + ed > smax) begin
      m.sum = smax;
      m.sat = 1;
    end else begin
      m.sum = m.sum + ed;
    end
    if (ed > m.maxed) begin
      m.maxed = ed;
      m.maxa  = a;
      m.maxb  = b;
    end
  endfunction

  function automatic void model_clear();
    m_main = '{default: 0};
    m_sat  = '{default: 0};
  endfunction

  task automatic cmp_res(input string tag, input mres_t e, input longint c, input longint er,
                         input longint s, input longint mx, input longint ma, input longint mb,
                         input longint st);
    check({tag, "_sample_cnt"}, c, e.cnt);
    check({tag, "_err_cnt"}, er, e.err);
    check({tag, "_sum_ed"}, s, e.sum);
    check({tag, "_max_ed"}, mx, e.maxed);
    check({tag, "_max_a"}, ma, e.maxa);
    check({tag, "_max_b"}, mb, e.maxb);
    check({tag, "_sat"}, st, e.sat);
  endtask

  task automatic monitor();
    logic dp, sdp;
    mres_t e;
    dp = 1'b0;
    sdp = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !dp) begin
        if (q_main.size() == 0) check("main_unexpected_done", done, 0);
        else begin
          e = q_main.pop_front();
          cmp_res("main", e, sample_cnt, err_cnt, sum_ed, max_ed, max_a, max_b, sat);
        end
      end
      if (s_done && !sdp) begin
        if (q_sat.size() == 0) check("satdut_unexpected_done", s_done, 0);
        else begin
          e = q_sat.pop_front();
          cmp_res("satdut", e, s_sample_cnt, s_err_cnt, s_sum_ed, s_max_ed, s_max_a, s_max_b, s_sat);
        end
      end
      dp  = done;
      sdp = s_done;
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    sync();
    start = 1'b0;
  endtask

  // Entered and left at 1 ns after a rising edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r,
                      input bit last, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) sync();
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_r = r;
    in_last = last;
    model_step(m_main, a, b, r, ACC_W);
    model_step(m_sat, a, b, r, ACC_S);
    if (last) begin
      q_main.push_back(m_main);
      q_sat.push_back(m_sat);
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", in_ready, 1);
        break;
      end
    end
    sync();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_rand(input bit last, input int gap);
    logic [7:0] a, b;
    logic [15:0] ex, r;
    a = 8'($urandom);
    b = 8'($urandom);
    ex = 16'(a) * 16'(b);
    case ($urandom_range(0, 3))
      0:       r = ex;
      1:       r = ex + 16'($urandom_range(1, 5));
      2:       r = ex - 16'($urandom_range(1, 300));
      default: r = 16'($urandom);
    endcase
    send(a, b, r, last, gap);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", done, 1);
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
  endfunction

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0; in_r = '0;
    model_clear();
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sample_cnt", sample_cnt, 0);
    check("rst_sum_ed", sum_ed, 0);
    check("rst_sat", sat, 0);
    sync();
    rst = 1'b0;

    // Samples offered in IDLE are ignored.
    in_valid = 1'b1; in_a = 8'd7; in_b = 8'd9; in_r = 16'd0;
    repeat (4) @(negedge clk);
    check("idle_ignore_cnt", sample_cnt, 0);
    check("idle_ignore_busy", busy, 0);
    check("idle_ignore_ready", in_ready, 0);
    sync();
    in_valid = 1'b0;

    // Zero-error sample with explicit latency checks.
    model_clear();
    pulse_start();
    @(negedge clk);
    check("start_busy", busy, 1);
    check("start_ready", in_ready, 1);
    sync();
    send(8'd255, 8'd255, 16'd65025, 1'b1, 0);
    @(negedge clk);
    check("drain_ready", in_ready, 0);
    check("drain_done_n0", done, 0);
    @(negedge clk);
    check("drain_done_n1", done, 0);
    check("cnt_before_n2", sample_cnt, 0);
    @(negedge clk);
    check("done_at_n2", done, 1);
    check("cnt_at_n2", sample_cnt, 1);
    sync();

    // Two error samples.
    model_clear();
    pulse_start();
    send(8'd255, 8'd255, 16'd64000, 1'b0, 0);
    send(8'd3, 8'd5, 16'd14, 1'b1, 0);
    wait_done();
    check("err_frame_sum", sum_ed, 1026);
    sync();

    // Tie on max, with start arriving together with the last accept.
    model_clear();
    pulse_start();
    send(8'd255, 8'd255, 16'd64000, 1'b0, 0);
    send(8'd3, 8'd5, 16'd14, 1'b0, 0);
    start = 1'b1;
    send(8'd5, 8'd5, 16'd1050, 1'b1, 0);
    start = 1'b0;
    wait_done();
    check("tie_max_a", max_a, 255);

    // Samples offered in DONE are ignored; start then clears metrics.
    in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7; in_r = 16'd1;
    repeat (4) @(negedge clk);
    check("done_ignore_cnt", sample_cnt, m_main.cnt);
    check("done_ignore_err", err_cnt, m_main.err);
    check("done_ignore_ready", in_ready, 0);
    check("done_held", done, 1);
    sync();
    in_valid = 1'b0;
    model_clear();
    pulse_start();
    @(negedge clk);
    check("clr_sample_cnt", sample_cnt, 0);
    check("clr_err_cnt", err_cnt, 0);
    check("clr_sum_ed", sum_ed, 0);
    check("clr_max_ed", max_ed, 0);
    check("clr_max_a", max_a, 0);
    check("clr_done", done, 0);
    sync();
    for (int i = 0; i < 15; i++) send_rand(i == 14, rgap());
    wait_done();
    sync();

    // Reset in the middle of a frame.
    model_clear();
    pulse_start();
    for (int i = 0; i < 10; i++) send_rand(1'b0, rgap());
    #3 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_done", done, 0);
    check("midrst_sample_cnt", sample_cnt, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_max_ed", max_ed, 0);
    sync();
    rst = 1'b0;
    sync();

    // Random frames.
    for (int f = 0; f < 3; f++) begin
      model_clear();
      pulse_start();
      n = int'($urandom_range(5, 40));
      for (int i = 0; i < n; i++) send_rand(i == n - 1, rgap());
      wait_done();
      sync();
    end

    // Saturation of the 8-bit accumulator build.
    model_clear();
    pulse_start();
    send(8'd16, 8'd16, 16'd0, 1'b0, 0);
    send(8'd16, 8'd16, 16'd0, 1'b1, 0);
    wait_done();
    repeat (5) @(negedge clk);
    check("sat_hold_flag", s_sat, 1);
    check("sat_hold_sum", s_sum_ed, 255);
    check("nosat_main_sum", sum_ed, 512);
    sync();
    model_clear();
    pulse_start();
    @(negedge clk);
    check("sat_clear_flag", s_sat, 0);
    check("sat_clear_sum", s_sum_ed, 0);
    sync();

    // Exhaustive exact sweep; a start mid-frame must be ignored.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        if (a == 0 && b == 100) start = 1'b1;
        send(8'(a), 8'(b), 16'(a * b), (a == 255 && b == 255),
             ($urandom_range(0, 31) == 0) ? 1 : 0);
        start = 1'b0;
      end
    end
    @(negedge clk);
    check("sweep_ready_after_last", in_ready, 0);
    wait_done();
    check("sweep_sample_cnt", sample_cnt, 65536);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", longint'(q_main.size() + q_sat.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
